// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands one nibble per clock through a
// single 4-bit add slice, with the inter-nibble carry held in a register.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             co_q;
  logic             busy_q;
  logic             done_q;
  logic [KW-1:0]    k_q;

  logic [4:0]       slice_d;
  logic [WIDTH-1:0] psum_d;

  assign slice_d = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
  // Each new nibble enters at the top, so after N cycles nibble 0 sits at the bottom.
  assign psum_d  = {slice_d[3:0], psum_q[WIDTH-1:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            psum_q  <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          psum_q  <= psum_d;
          carry_q <= slice_d[4];
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            sum_q   <= psum_d;
            co_q    <= slice_d[4];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;

endmodule
